// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction memory
// and fills the IF/ID register, with a one-entry skid buffer for stalls and a drain state for redirects.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   ifid_valid,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc_next,
    output logic [15:0]            ifid_immediate
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HELD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state, state_n;
    logic [PC_WIDTH-1:0]    pc, pc_n;
    logic [PC_WIDTH-1:0]    drain_addr, drain_addr_n;
    logic [INSTR_WIDTH-1:0] buf_instr, buf_instr_n;
    logic [PC_WIDTH-1:0]    buf_pc_next, buf_pc_next_n;
    logic                   ifid_valid_n;
    logic [INSTR_WIDTH-1:0] ifid_instr_n;
    logic [PC_WIDTH-1:0]    ifid_pc_next_n;

    logic                   redirect;
    logic                   completion;
    logic [PC_WIDTH-1:0]    target;
    logic [PC_WIDTH-1:0]    pc_plus1;

    // Branch wins over jump when both resolve in the same cycle.
    assign redirect   = branch_taken | jump;
    assign target     = branch_taken ? branch_target : jump_target;
    assign pc_plus1   = pc + PC_ONE;

    // While draining, the abandoned request must stay on the bus until memory accepts it.
    assign imem_req   = (state != S_HELD);
    assign imem_addr  = (state == S_DRAIN) ? drain_addr : pc;
    assign completion = imem_req & imem_ready;

    assign ifid_immediate = ifid_instr[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            drain_addr   <= '0;
            buf_instr    <= '0;
            buf_pc_next  <= '0;
            ifid_valid   <= 1'b0;
            ifid_instr   <= '0;
            ifid_pc_next <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            drain_addr   <= drain_addr_n;
            buf_instr    <= buf_instr_n;
            buf_pc_next  <= buf_pc_next_n;
            ifid_valid   <= ifid_valid_n;
            ifid_instr   <= ifid_instr_n;
            ifid_pc_next <= ifid_pc_next_n;
        end
    end

    always_comb begin
        state_n        = state;
        pc_n           = pc;
        drain_addr_n   = drain_addr;
        buf_instr_n    = buf_instr;
        buf_pc_next_n  = buf_pc_next;
        ifid_valid_n   = ifid_valid;
        ifid_instr_n   = ifid_instr;
        ifid_pc_next_n = ifid_pc_next;

        unique case (state)
            S_FETCH: begin
                if (redirect) begin
                    pc_n         = target;
                    ifid_valid_n = 1'b0;
                    if (!completion) begin
                        drain_addr_n = pc;
                        state_n      = S_DRAIN;
                    end
                end else if (completion) begin
                    pc_n = pc_plus1;
                    if (stall) begin
                        buf_instr_n   = imem_rdata;
                        buf_pc_next_n = pc_plus1;
                        state_n       = S_HELD;
                    end else begin
                        ifid_valid_n   = 1'b1;
                        ifid_instr_n   = imem_rdata;
                        ifid_pc_next_n = pc_plus1;
                    end
                end else if (!stall) begin
                    ifid_valid_n = 1'b0;
                end
            end

            S_HELD: begin
                if (redirect) begin
                    pc_n          = target;
                    ifid_valid_n  = 1'b0;
                    buf_instr_n   = '0;
                    buf_pc_next_n = '0;
                    state_n       = S_FETCH;
                end else if (!stall) begin
                    ifid_valid_n   = 1'b1;
                    ifid_instr_n   = buf_instr;
                    ifid_pc_next_n = buf_pc_next;
                    state_n        = S_FETCH;
                end
            end

            S_DRAIN: begin
                if (redirect) begin
                    pc_n         = target;
                    ifid_valid_n = 1'b0;
                end else if (!stall) begin
                    ifid_valid_n = 1'b0;
                end
                if (imem_ready) begin
                    state_n = S_FETCH;
                end
            end

            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a zero-latency memory returns 0x1000_0000 | address,
// and each task walks one scenario against hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        jump;
    logic [7:0]  jump_target;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc_next;
    logic [15:0] ifid_immediate;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (32),
        .RESET_PC    (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc_next   (ifid_pc_next),
        .ifid_immediate (ifid_immediate)
    );

    assign imem_rdata = 32'h1000_0000 | {24'h0, imem_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        jump = 1'b0; jump_target = 8'h00; imem_ready = 1'b1;
        #1;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 00000000", ifid_instr); end
        checks++; if (ifid_pc_next !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc_next: got %h expected 00", ifid_pc_next); end
        checks++; if (ifid_immediate !== 16'h0) begin errors++; $display("[TB] FAIL reset_imm: got %h expected 0000", ifid_immediate); end
        #11;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL release_addr: got %h expected 00", imem_addr); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_valid: got %b expected 0", ifid_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] k8;
        for (int k = 0; k < 5; k++) begin
            step();
            k8 = 8'(k);
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", k, ifid_valid); end
            checks++; if (ifid_pc_next !== k8 + 8'h01) begin errors++; $display("[TB] FAIL b2b_pc_next[%0d]: got %h expected %h", k, ifid_pc_next, k8 + 8'h01); end
            checks++; if (ifid_immediate !== {8'h00, k8}) begin errors++; $display("[TB] FAIL b2b_imm[%0d]: got %h expected %h", k, ifid_immediate, {8'h00, k8}); end
            checks++; if (imem_addr !== k8 + 8'h01) begin errors++; $display("[TB] FAIL b2b_addr[%0d]: got %h expected %h", k, imem_addr, k8 + 8'h01); end
        end
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_bubble[%0d]: got %b expected 0", k, ifid_valid); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_req[%0d]: got %b expected 1", k, imem_req); end
            checks++; if (imem_addr !== 8'h05) begin errors++; $display("[TB] FAIL wait_addr[%0d]: got %h expected 05", k, imem_addr); end
        end
        imem_ready = 1'b1;
        step();
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_done_valid: got %b expected 1", ifid_valid); end
        checks++; if (ifid_pc_next !== 8'h06) begin errors++; $display("[TB] FAIL wait_done_pc_next: got %h expected 06", ifid_pc_next); end
        checks++; if (imem_addr !== 8'h06) begin errors++; $display("[TB] FAIL wait_done_addr: got %h expected 06", imem_addr); end
    endtask

    task automatic test_stall();
        step();
        checks++; if (ifid_pc_next !== 8'h07) begin errors++; $display("[TB] FAIL pre_stall_pc_next: got %h expected 07", ifid_pc_next); end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (ifid_instr !== 32'h1000_0006) begin errors++; $display("[TB] FAIL stall_instr[%0d]: got %h expected 10000006", k, ifid_instr); end
            checks++; if (ifid_pc_next !== 8'h07) begin errors++; $display("[TB] FAIL stall_pc_next[%0d]: got %h expected 07", k, ifid_pc_next); end
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", k, ifid_valid); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req[%0d]: got %b expected 0", k, imem_req); end
        end
        stall = 1'b0;
        step();
        checks++; if (ifid_instr !== 32'h1000_0007) begin errors++; $display("[TB] FAIL unload_instr: got %h expected 10000007", ifid_instr); end
        checks++; if (ifid_pc_next !== 8'h08) begin errors++; $display("[TB] FAIL unload_pc_next: got %h expected 08", ifid_pc_next); end
        checks++; if (imem_addr !== 8'h08) begin errors++; $display("[TB] FAIL unload_addr: got %h expected 08", imem_addr); end
        step();
        checks++; if (ifid_pc_next !== 8'h09) begin errors++; $display("[TB] FAIL resume_pc_next: got %h expected 09", ifid_pc_next); end
        step();
        checks++; if (imem_addr !== 8'h0A) begin errors++; $display("[TB] FAIL resume_addr: got %h expected 0a", imem_addr); end
    endtask

    task automatic test_branch_drain();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h40;
        step();
        branch_taken = 1'b0;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_flush: got %b expected 0", ifid_valid); end
        checks++; if (imem_addr !== 8'h0A) begin errors++; $display("[TB] FAIL drain_addr0: got %h expected 0a", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL drain_req: got %b expected 1", imem_req); end
        step();
        checks++; if (imem_addr !== 8'h0A) begin errors++; $display("[TB] FAIL drain_addr1: got %h expected 0a", imem_addr); end
        imem_ready = 1'b1;
        step();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_discard: got %b expected 0", ifid_valid); end
        checks++; if (imem_addr !== 8'h40) begin errors++; $display("[TB] FAIL target_addr: got %h expected 40", imem_addr); end
        step();
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL target_valid: got %b expected 1", ifid_valid); end
        checks++; if (ifid_pc_next !== 8'h41) begin errors++; $display("[TB] FAIL target_pc_next: got %h expected 41", ifid_pc_next); end
        checks++; if (ifid_instr !== 32'h1000_0040) begin errors++; $display("[TB] FAIL target_instr: got %h expected 10000040", ifid_instr); end
    endtask

    task automatic test_priority();
        branch_taken = 1'b1; branch_target = 8'h20; jump = 1'b1; jump_target = 8'h30;
        step();
        branch_taken = 1'b0; jump = 1'b0;
        checks++; if (imem_addr !== 8'h20) begin errors++; $display("[TB] FAIL prio_addr: got %h expected 20", imem_addr); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_flush: got %b expected 0", ifid_valid); end
        step();
        checks++; if (ifid_pc_next !== 8'h21) begin errors++; $display("[TB] FAIL prio_pc_next: got %h expected 21", ifid_pc_next); end
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 8'hFF;
        step();
        jump = 1'b0;
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_issue: got %h expected ff", imem_addr); end
        step();
        checks++; if (ifid_pc_next !== 8'h00) begin errors++; $display("[TB] FAIL wrap_pc_next: got %h expected 00", ifid_pc_next); end
        checks++; if (ifid_immediate !== 16'h00FF) begin errors++; $display("[TB] FAIL wrap_imm: got %h expected 00ff", ifid_immediate); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 00", imem_addr); end
        step();
        checks++; if (imem_addr !== 8'h01) begin errors++; $display("[TB] FAIL wrap_next_addr: got %h expected 01", imem_addr); end
    endtask

    task automatic test_reset_in_drain();
        imem_ready = 1'b0; jump = 1'b1; jump_target = 8'h80;
        step();
        jump = 1'b0;
        checks++; if (imem_addr !== 8'h01) begin errors++; $display("[TB] FAIL rdrain_addr: got %h expected 01", imem_addr); end
        checks++; if (ifid_instr !== 32'h1000_0000) begin errors++; $display("[TB] FAIL rdrain_instr: got %h expected 10000000", ifid_instr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL async_instr: got %h expected 00000000", ifid_instr); end
        checks++; if (ifid_pc_next !== 8'h00) begin errors++; $display("[TB] FAIL async_pc_next: got %h expected 00", ifid_pc_next); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid: got %b expected 0", ifid_valid); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL async_addr: got %h expected 00", imem_addr); end
        imem_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rerelease_req: got %b expected 1", imem_req); end
        step();
        checks++; if (ifid_pc_next !== 8'h01) begin errors++; $display("[TB] FAIL rerelease_pc_next: got %h expected 01", ifid_pc_next); end
        checks++; if (ifid_instr !== 32'h1000_0000) begin errors++; $display("[TB] FAIL rerelease_instr: got %h expected 10000000", ifid_instr); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_stall();
        test_branch_drain();
        test_priority();
        test_wrap();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 8-bit-PC CPU. Holds the program counter and issues word-addressed requests to instruction memory.
- Captures returned instructions into the IF/ID pipeline register, together with PC+1 (program_counter) and instr[15:0] (immediate). These two fields feed the branch target calculator downstream.
- Consumes the resolved branch target (BT) and jump target to redirect fetch. Supports decode stalls and wrong-path discard.

Parameters:
- PC_WIDTH, 8, program counter / instruction address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold IF/ID contents (from hazard unit).
- branch_taken  input  1  redirect to branch_target this cycle.
- branch_target  input  PC_WIDTH  branch target (BT).
- jump  input  1  redirect to jump_target this cycle.
- jump_target  input  PC_WIDTH  jump destination.
- imem_req  output  1  instruction memory request.
- imem_addr  output  PC_WIDTH  request word address.
- imem_ready  input  1  request accepted and imem_rdata valid this cycle.
- imem_rdata  input  INSTR_WIDTH  fetched instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_instr  output  INSTR_WIDTH  fetched instruction.
- ifid_pc_next  output  PC_WIDTH  address of that instruction + 1.
- ifid_immediate  output  16  ifid_instr[15:0].

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_FETCH, buffer empty.
  - ifid_valid=0, ifid_instr=0, ifid_pc_next=0, ifid_immediate=0.
  - imem_req is 1 immediately after reset release (S_FETCH).
  - Reset mid-transaction abandons it; no IF/ID write.
- Redirect and completion:
  - redirect = branch_taken | jump. branch_taken has priority when both are high. target = branch_taken ? branch_target : jump_target.
  - Completion = imem_req & imem_ready.
- Address arithmetic: pc+1 is modulo 2^PC_WIDTH, so 8'hFF wraps to 8'h00.
- S_FETCH:
  - imem_req=1, imem_addr=pc. Request and address stay stable until imem_ready.
  - Completion, no redirect, stall=0: IF/ID <= {1, rdata, pc+1}; pc<=pc+1; stay in S_FETCH. This gives back-to-back fetch of one instruction per cycle with zero-wait memory.
  - Completion, no redirect, stall=1: rdata and pc+1 go to the one-entry buffer; pc<=pc+1; go to S_HELD; IF/ID unchanged.
  - No completion, no redirect: if stall=0, ifid_valid<=0 (bubble); if stall=1, IF/ID held.
  - Redirect with completion: data discarded; pc<=target; stay in S_FETCH.
  - Redirect without completion: latch drain_addr<=pc; pc<=target; go to S_DRAIN.
- S_HELD:
  - imem_req=0.
  - stall=0: IF/ID <= buffer (valid=1); go to S_FETCH.
  - stall=1: hold.
  - Redirect: buffer cleared; pc<=target; go to S_FETCH.
- S_DRAIN:
  - imem_req=1, imem_addr=drain_addr (outstanding request held stable).
  - On imem_ready: response discarded; go to S_FETCH.
  - Redirect in S_DRAIN: pc<=new target; stay in S_DRAIN (or leave if ready the same cycle).
- IF/ID flush and bubbles:
  - Any redirect forces ifid_valid<=0 in the same cycle, overriding stall.
  - While not in S_FETCH with stall=0, IF/ID is written as a bubble (valid=0). Exception: the S_HELD unload.
- Output behaviour:
  - ifid_immediate is continuously ifid_instr[15:0].
  - Output latency from address issue to ifid_valid is 1 cycle after completion.

Test Plan:
- Reset release with imem_ready tied 1, rdata=0x1000_0000|addr -> imem_addr 00,01,02…; ifid_valid rises the cycle after the first edge; ifid_pc_next=01,02,03; ifid_immediate=0x0000,0x0001,0x0002.
- imem_ready held low 3 cycles on addr 05 -> imem_req/imem_addr=05 stable; ifid_valid=0 bubbles; the fourth-cycle completion yields ifid_pc_next=06.
- stall=1 asserted when addr 07 completes -> IF/ID keeps the addr-06 instruction; imem_req=0. After stall drops, ifid_instr=data(07), ifid_pc_next=08, then fetch resumes at 08.
- branch_taken=1, branch_target=8'h40 while addr 0A is waiting (ready=0) -> ifid_valid=0; imem_addr stays 0A until ready; 0A data discarded; next request addr=40; ifid_pc_next=41.
- branch_taken and jump asserted together (branch_target=20, jump_target=30) with ready=1 -> next fetch at 20, never 30. Separately, pc=FF fetch -> ifid_pc_next=00, next address 00.
- rst_n pulsed low during S_DRAIN -> outputs zero asynchronously; first request after release is at RESET_PC.
